commit_trace_buffer: RTL and testbench

- Synthesizable retirement trace capture for riscv_pipelined_core; sits beside the WB stage and snoops every retired instruction (valid MEM/WB entry).
- Stores PC, destination register, write data and write-enable in a DEPTH-entry circular buffer, with three capture modes: wrap, stop-on-full, and PC trigger with post-trigger count.
- A registered random-access read port lets a bench or debug module dump the trace after the run instead of printing every cycle.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/trace_ram.sv | 42 ++++
 rtl/commit_trace_buffer.sv | 179 +++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions plus the retirement-trace types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // One captured retirement. we is already qualified with rd != x0.
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       data;
        logic                  we;
    } trace_entry_t;

    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_CAPTURE = 2'd1,
        TR_POST    = 2'd2,
        TR_DONE    = 2'd3
    } trace_state_t;

    // Mode 3 is reserved and decodes as wrap: nothing matches it explicitly.
    localparam logic [1:0] TR_WRAP      = 2'd0;
    localparam logic [1:0] TR_STOP_FULL = 2'd1;
    localparam logic [1:0] TR_TRIGGER   = 2'd2;

endpackage

// File: rtl/trace_ram.sv
// DEPTH-entry trace storage: one write port, one registered read port.
// Latency: read data appears the cycle after rd_en; same-slot write in that cycle is not seen.
// Backpressure: none, both ports accept every cycle.
// Ports: wr_en/wr_idx/wr_entry write one slot; rd_en/rd_ptr select a slot whose
// contents land in rd_entry next cycle (zero when rd_en was low or under reset).
module trace_ram
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  trace_entry_t     wr_entry,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_ptr,
    output trace_entry_t     rd_entry
);

    trace_entry_t mem [DEPTH];

    // Array is left unreset; only the slots below count are ever exposed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    // Non-enabled reads return zero so the top never has to mask the fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_entry <= '0;
        end else if (rd_en) begin
            rd_entry <= mem[rd_ptr];
        end else begin
            rd_entry <= '0;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture beside WB: circular buffer with wrap / stop-on-full / PC-trigger modes.
// Latency: capture in the retire cycle; random-access read returns one cycle after rd_req.
// Backpressure: none; the core is never stalled, retirements outside capture are simply dropped.
// Ports: wb_* snoop the MEM/WB entry; cfg_*/arm/stop control capture; rd_req/rd_idx
// read entry rd_idx (0 = oldest) into rd_*; state/count/wrapped/triggered/commit_total
// report status.
module commit_trace_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_write_data,
    input  logic [1:0]            cfg_mode,
    input  logic [XLEN-1:0]       cfg_trig_pc,
    input  logic [CNT_W-1:0]      cfg_post,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  rd_req,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [XLEN-1:0]       rd_pc,
    output logic [REG_ADDR_W-1:0] rd_rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic                  rd_we,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      count,
    output logic                  wrapped,
    output logic                  triggered,
    output logic [31:0]           commit_total
);

    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);

    trace_state_t     state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             triggered_q, triggered_d;
    logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
    logic             do_write;
    logic [CNT_W-1:0] trig_post;
    trace_entry_t     wr_entry, rd_entry;
    logic             rd_hit;
    logic [IDX_W-1:0] oldest, rd_ptr;

    // Post-trigger window can never exceed what the buffer holds after the trigger entry.
    assign trig_post = (cfg_post > MAX_POST) ? MAX_POST : cfg_post;

    assign wr_entry.pc      = wb_pc;
    assign wr_entry.rd_addr = wb_rd_addr;
    assign wr_entry.data    = wb_write_data;
    assign wr_entry.we      = wb_reg_write && (wb_rd_addr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= TR_IDLE;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wrapped_q    <= 1'b0;
            triggered_q  <= 1'b0;
            post_cnt_q   <= '0;
            commit_total <= '0;
            rd_valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            triggered_q <= triggered_d;
            post_cnt_q  <= post_cnt_d;
            rd_valid    <= rd_hit;
            if (wb_valid && (commit_total != '1)) begin
                commit_total <= commit_total + 32'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        triggered_d = triggered_q;
        post_cnt_d  = post_cnt_q;
        do_write    = 1'b0;

        if (arm) begin
            // Arm wins over stop and drops any retirement in the same cycle.
            state_d     = TR_CAPTURE;
            wr_ptr_d    = '0;
            count_d     = '0;
            wrapped_d   = 1'b0;
            triggered_d = 1'b0;
            post_cnt_d  = '0;
        end else begin
            do_write = wb_valid && ((state_q == TR_CAPTURE) || (state_q == TR_POST));

            if (do_write) begin
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
                if (count_q != FULL) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    wrapped_d = 1'b1;
                end
            end

            case (state_q)
                TR_CAPTURE: begin
                    if (do_write) begin
                        if ((cfg_mode == TR_STOP_FULL) && (count_q == FULL - CNT_W'(1))) begin
                            state_d = TR_DONE;
                        end else if ((cfg_mode == TR_TRIGGER) && (wb_pc == cfg_trig_pc)) begin
                            triggered_d = 1'b1;
                            if (trig_post == '0) begin
                                state_d = TR_DONE;
                            end else begin
                                post_cnt_d = trig_post;
                                state_d    = TR_POST;
                            end
                        end
                    end
                end
                TR_POST: begin
                    if (do_write) begin
                        post_cnt_d = post_cnt_q - CNT_W'(1);
                        if (post_cnt_q == CNT_W'(1)) begin
                            state_d = TR_DONE;
                        end
                    end
                end
                default: ;
            endcase

            // Stop still lets this cycle's retirement land (handled above).
            if (stop && ((state_q == TR_CAPTURE) || (state_q == TR_POST))) begin
                state_d = TR_DONE;
            end
        end
    end

    // Once wrapped, the slot about to be overwritten is the oldest one.
    assign oldest = wrapped_q ? wr_ptr_q : '0;
    assign rd_ptr = oldest + rd_idx;
    assign rd_hit = rd_req && ({1'b0, rd_idx} < count_q);

    trace_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (do_write),
        .wr_idx   (wr_ptr_q),
        .wr_entry (wr_entry),
        .rd_en    (rd_hit),
        .rd_ptr   (rd_ptr),
        .rd_entry (rd_entry)
    );

    assign rd_pc      = rd_entry.pc;
    assign rd_rd_addr = rd_entry.rd_addr;
    assign rd_data    = rd_entry.data;
    assign rd_we      = rd_entry.we;

    assign state     = state_q;
    assign count     = count_q;
    assign wrapped   = wrapped_q;
    assign triggered = triggered_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_write_data;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_trig_pc;
    logic [4:0]  cfg_post;
    logic        arm;
    logic        stop;
    logic        rd_req;
    logic [3:0]  rd_idx;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [4:0]  rd_rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        wrapped;
    logic        triggered;
    logic [31:0] commit_total;

    int errors = 0;
    int checks = 0;
    int exp_total = 0;

    commit_trace_buffer #(.DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_write_data (wb_write_data),
        .cfg_mode      (cfg_mode),
        .cfg_trig_pc   (cfg_trig_pc),
        .cfg_post      (cfg_post),
        .arm           (arm),
        .stop          (stop),
        .rd_req        (rd_req),
        .rd_idx        (rd_idx),
        .rd_valid      (rd_valid),
        .rd_pc         (rd_pc),
        .rd_rd_addr    (rd_rd_addr),
        .rd_data       (rd_data),
        .rd_we         (rd_we),
        .state         (state),
        .count         (count),
        .wrapped       (wrapped),
        .triggered     (triggered),
        .commit_total  (commit_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] trig;
        logic [4:0]  post;
        int          n;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic        wr;
        logic        trg;
        logic [3:0]  ia;
        logic [31:0] pa;
        logic [3:0]  ib;
        logic [31:0] pb;
    } vec_t;

    vec_t vecs [6];

    localparam logic [31:0] DMASK = 32'hA5A5_0000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] d, input logic w);
        wb_valid      = 1'b1;
        wb_pc         = pc;
        wb_rd_addr    = rd;
        wb_write_data = d;
        wb_reg_write  = w;
        tick();
        wb_valid  = 1'b0;
        exp_total = exp_total + 1;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 0; wb_pc = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_write_data = 0;
        cfg_mode = 0; cfg_trig_pc = 0; cfg_post = 0; arm = 0; stop = 0; rd_req = 0; rd_idx = 0;

        //             mode trig      post n   st cnt wr trg ia  pa       ib  pb
        vecs[0] = '{2'd1, 32'h0,  5'd0,  20, 2'd3, 5'd16, 1'b0, 1'b0, 4'd0, 32'h00, 4'd15, 32'h3C};
        vecs[1] = '{2'd0, 32'h0,  5'd0,  20, 2'd1, 5'd16, 1'b1, 1'b0, 4'd0, 32'h10, 4'd15, 32'h4C};
        vecs[2] = '{2'd2, 32'h20, 5'd3,  17, 2'd3, 5'd12, 1'b0, 1'b1, 4'd8, 32'h20, 4'd11, 32'h2C};
        vecs[3] = '{2'd3, 32'h0,  5'd0,  18, 2'd1, 5'd16, 1'b1, 1'b0, 4'd0, 32'h08, 4'd15, 32'h44};
        vecs[4] = '{2'd2, 32'h08, 5'd0,  10, 2'd3, 5'd3,  1'b0, 1'b1, 4'd0, 32'h00, 4'd2,  32'h08};
        vecs[5] = '{2'd2, 32'h00, 5'd16, 20, 2'd3, 5'd16, 1'b0, 1'b1, 4'd0, 32'h00, 4'd15, 32'h3C};

        #12;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_wrapped", 64'(wrapped), 64'd0);
        chk("reset_trig", 64'(triggered), 64'd0);
        chk("reset_total", 64'(commit_total), 64'd0);
        chk("reset_rdvalid", 64'(rd_valid), 64'd0);
        chk("reset_rdpc", 64'(rd_pc), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            cfg_mode    = vecs[v].mode;
            cfg_trig_pc = vecs[v].trig;
            cfg_post    = vecs[v].post;
            pulse_arm();
            for (int i = 0; i < vecs[v].n; i++) begin
                retire(32'(i * 4), 5'(i), 32'(i * 4) ^ DMASK, 1'b1);
            end
            chk($sformatf("v%0d_state", v), 64'(state), 64'(vecs[v].st));
            chk($sformatf("v%0d_count", v), 64'(count), 64'(vecs[v].cnt));
            chk($sformatf("v%0d_wrapped", v), 64'(wrapped), 64'(vecs[v].wr));
            chk($sformatf("v%0d_trig", v), 64'(triggered), 64'(vecs[v].trg));
            chk($sformatf("v%0d_total", v), 64'(commit_total), 64'(exp_total));
            do_read(vecs[v].ia);
            chk($sformatf("v%0d_a_valid", v), 64'(rd_valid), 64'd1);
            chk($sformatf("v%0d_a_pc", v), 64'(rd_pc), 64'(vecs[v].pa));
            chk($sformatf("v%0d_a_data", v), 64'(rd_data), 64'(vecs[v].pa ^ DMASK));
            do_read(vecs[v].ib);
            chk($sformatf("v%0d_b_valid", v), 64'(rd_valid), 64'd1);
            chk($sformatf("v%0d_b_pc", v), 64'(rd_pc), 64'(vecs[v].pb));
        end

        // Read latency: idle before the request, valid exactly one cycle after, gone after release.
        tick();
        chk("lat_before", 64'(rd_valid), 64'd0);
        do_read(4'd3);
        chk("lat_after", 64'(rd_valid), 64'd1);
        tick();
        chk("lat_release", 64'(rd_valid), 64'd0);
        chk("lat_release_pc", 64'(rd_pc), 64'd0);

        // add.hex retirements in stop-on-full mode, then an x0 write.
        cfg_mode = 2'd1;
        pulse_arm();
        retire(32'h0, 5'd1, 32'd5, 1'b1);
        retire(32'h4, 5'd2, 32'd3, 1'b1);
        retire(32'h8, 5'd3, 32'd8, 1'b1);
        do_read(4'd5);
        chk("oob_valid", 64'(rd_valid), 64'd0);
        chk("oob_pc", 64'(rd_pc), 64'd0);
        chk("oob_data", 64'(rd_data), 64'd0);
        retire(32'hC, 5'd0, 32'h77, 1'b1);
        for (int i = 0; i < 3; i++) begin
            do_read(4'(i));
            chk($sformatf("add%0d_rd", i), 64'(rd_rd_addr), 64'(i + 1));
            chk($sformatf("add%0d_we", i), 64'(rd_we), 64'd1);
        end
        do_read(4'd0);
        chk("add0_data", 64'(rd_data), 64'd5);
        do_read(4'd1);
        chk("add1_data", 64'(rd_data), 64'd3);
        do_read(4'd2);
        chk("add2_data", 64'(rd_data), 64'd8);
        do_read(4'd3);
        chk("x0_we", 64'(rd_we), 64'd0);
        chk("x0_data", 64'(rd_data), 64'h77);

        // Arm with a same-cycle retirement: retirement dropped.
        wb_valid = 1'b1; wb_pc = 32'h500; arm = 1'b1;
        tick();
        wb_valid = 1'b0; arm = 1'b0; exp_total = exp_total + 1;
        chk("arm_wb_count", 64'(count), 64'd0);
        chk("arm_wb_total", 64'(commit_total), 64'(exp_total));

        // Stop with a same-cycle retirement: entry kept, DONE.
        stop = 1'b1;
        retire(32'h100, 5'd4, 32'h11, 1'b1);
        stop = 1'b0;
        chk("stopwb_state", 64'(state), 64'd3);
        chk("stopwb_count", 64'(count), 64'd1);
        do_read(4'd0);
        chk("stopwb_pc", 64'(rd_pc), 64'h100);

        // DONE ignores retirements and stop.
        stop = 1'b1;
        retire(32'h104, 5'd4, 32'h12, 1'b1);
        stop = 1'b0;
        chk("done_count", 64'(count), 64'd1);
        chk("done_state", 64'(state), 64'd3);

        // Arm and stop together from DONE.
        arm = 1'b1; stop = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0;
        chk("armstop_state", 64'(state), 64'd1);
        chk("armstop_count", 64'(count), 64'd0);

        // Reset in the middle of POST.
        cfg_mode = 2'd2; cfg_trig_pc = 32'h0; cfg_post = 5'd5;
        pulse_arm();
        retire(32'h0, 5'd1, 32'h1, 1'b1);
        retire(32'h4, 5'd2, 32'h2, 1'b1);
        chk("post_state", 64'(state), 64'd2);
        do_read(4'd1);
        chk("post_rd_pc", 64'(rd_pc), 64'h4);
        #2;
        reset = 1'b1;
        #1;
        exp_total = 0;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_trig", 64'(triggered), 64'd0);
        chk("rst_total", 64'(commit_total), 64'(exp_total));
        chk("rst_rdvalid", 64'(rd_valid), 64'd0);
        chk("rst_rdpc", 64'(rd_pc), 64'd0);
        chk("rst_rdrd", 64'(rd_rd_addr), 64'd0);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
